rom_stream_reader: RTL

Sequencer that sits directly upstream of the `rom_case` ROM: on a start command it issues a burst of byte reads from a base address, drives the ROM's `addr`/`ce`/`ren` pins, captures the returned `data`, and presents the bytes as a valid/ready stream with a last marker. A small credit-controlled FIFO decouples ROM read latency from downstream backpressure, so no returned byte is ever dropped.

---
 rtl/rom_stream_pkg.sv | 15 +
 rtl/sync_fifo.sv | 70 +++++++
 rtl/rom_stream_reader.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/rom_stream_pkg.sv
// Shared types and widths for the ROM stream reader.
// Imported by the sequencer top.
package rom_stream_pkg;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LW = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Push and pop in one cycle leave the count unchanged.
module sync_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next pointers, storage and occupancy
  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wp_q] = din;
      wp_d        = wp_q + 1'b1;
    end
    if (pop) begin
      rp_d = rp_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rp_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

  a_no_underflow: assert property (
    @(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/rom_stream_reader.sv
// Burst reader for a fixed-latency ROM, credit-limited
// so every returned byte fits in the output FIFO.
module rom_stream_reader
  import rom_stream_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int DEPTH  = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rom_addr,
  output logic          rom_ce,
  output logic          rom_ren,
  input  logic [DW-1:0] rom_data,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [LW-1:0]     issue_q, issue_d;
  logic [LW-1:0]     beat_q, beat_d;
  logic              done_q, done_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;

  logic [CW-1:0] occ;
  logic [CW-1:0] infl;
  logic          credit;
  logic          issue;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [DW:0]   head;

  // Reads still travelling through the ROM
  always_comb begin
    infl = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      infl = infl + CW'(pipe_q[i]);
    end
  end

  assign credit = (occ + infl) < DEPTH_C;
  assign issue  = (state_q == RUN) && (issue_q != '0) && credit;
  assign push   = pipe_q[RD_LAT-1];
  assign pop    = m_valid && m_ready;

  // Sequencer next state, counters and in-flight pipe
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    issue_d = issue_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    pipe_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    if (issue) begin
      addr_d  = addr_q + 1'b1;
      issue_d = issue_q - 1'b1;
    end
    if (push) begin
      beat_d = beat_q - 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d = RUN;
            addr_d  = base_addr;
            issue_d = len;
            beat_d  = len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (issue && issue_q == LW'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && m_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      issue_q <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      issue_q <= issue_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
      pipe_q  <= pipe_d;
    end
  end

  sync_fifo #(
    .W     (DW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (resetn),
    .push  (push),
    .din   ({beat_q == LW'(1), rom_data}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (occ)
  );

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign rom_addr = addr_q;
  assign rom_ce   = issue;
  assign rom_ren  = issue;
  assign m_valid  = !empty;
  assign m_data   = m_valid ? head[DW-1:0] : '0;
  assign m_last   = m_valid && head[DW];

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!resetn) !(push && full && !pop));

endmodule
